// File: rtl/vga_scan_sequencer.sv
// -----------------------------------------------------------------------------
// vga_scan_sequencer
//
// Raster timebase for the VGA output path. Produces the horizontal/vertical
// scan counters used by the VGA controller and sequences scan-out against the
// pixel read FIFO: the raster is held at (0,0) in blanking until the FIFO is
// primed, then free-runs. A FIFO underflow gates further reads for the rest of
// the frame; the block then re-primes so a frame never starts mid-line.
//
// Ports:
//   iCLK            pixel clock
//   iRST_N          asynchronous active-low reset
//   iEnable         scan-out enable (level)
//   iFifo_Level     words currently held in the pixel FIFO
//   iFifo_Empty     pixel FIFO empty flag
//   iRead_Req       read request from the VGA controller for this pixel
//   oH_Cont         horizontal scan counter
//   oV_Cont         vertical scan counter
//   oRead_Gate      1 = FIFO reads permitted
//   oFrame_Start    one-cycle pulse on the first cycle of each frame
//   oLine_Start     one-cycle pulse whenever H=0 while counting
//   oRunning        1 while the raster is counting (RUN or DRAIN)
//   oUnderflow_Cnt  saturating count of underflow events
//   oFrame_Cnt      frames started, wraps at 65535
//   oDbg_State      current FSM state (0 IDLE, 1 PRIME, 2 RUN, 3 DRAIN)
//
// Read contract: a FIFO read happens in a cycle only when oRead_Gate and
// iRead_Req are both 1 (downstream ANDs them). If that pair is 1 while
// iFifo_Empty is 1, the requested pixel was not available: that is an
// underflow, and oRead_Gate drops from the next cycle.
// -----------------------------------------------------------------------------
module vga_scan_sequencer #(
    parameter int H_SYNC_TOTAL = 800,
    parameter int V_SYNC_TOTAL = 525,
    parameter int H_BLANK      = 160,
    parameter int V_BLANK      = 45,
    parameter int PRIME_LEVEL  = 640,
    parameter int LVL_W        = 11
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iEnable,
    input  logic [LVL_W-1:0] iFifo_Level,
    input  logic             iFifo_Empty,
    input  logic             iRead_Req,
    output logic [15:0]      oH_Cont,
    output logic [15:0]      oV_Cont,
    output logic             oRead_Gate,
    output logic             oFrame_Start,
    output logic             oLine_Start,
    output logic             oRunning,
    output logic [7:0]       oUnderflow_Cnt,
    output logic [15:0]      oFrame_Cnt,
    output logic [1:0]       oDbg_State
);

    // Counters are 16 bits and the raster must fit; the (0,0) hold point is
    // only invisible on screen if it lies inside blanking.
    localparam bit CFG_OK = (H_SYNC_TOTAL >= 2) && (H_SYNC_TOTAL <= 65535) &&
                            (V_SYNC_TOTAL >= 1) && (V_SYNC_TOTAL <= 65535) &&
                            (H_BLANK >= 1) && (H_BLANK < H_SYNC_TOTAL) &&
                            (V_BLANK >= 0) && (V_BLANK < V_SYNC_TOTAL) &&
                            (LVL_W >= 1) && (LVL_W <= 30) &&
                            (PRIME_LEVEL >= 0) && (PRIME_LEVEL < (1 << LVL_W));

    if (!CFG_OK) begin : g_bad_cfg
        $error("vga_scan_sequencer: invalid raster/FIFO parameters");
    end

    localparam logic [15:0]      H_LAST    = 16'(H_SYNC_TOTAL - 1);
    localparam logic [15:0]      V_LAST    = 16'(V_SYNC_TOTAL - 1);
    localparam logic [LVL_W-1:0] PRIME_LVL = LVL_W'(PRIME_LEVEL);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    logic [15:0] r_h;
    logic [15:0] r_v;
    logic        r_read_gate;
    logic        r_frame_start;
    logic        r_line_start;
    logic        r_running;
    logic [7:0]  r_uf_cnt;
    logic [15:0] r_frame_cnt;

    logic        w_h_last;
    logic        w_v_last;
    logic        w_eof;
    logic [15:0] w_h_next;
    logic [15:0] w_v_next;
    logic        w_underflow;
    logic        w_primed;
    logic [7:0]  w_uf_cnt_next;

    assign w_h_last      = (r_h == H_LAST);
    assign w_v_last      = (r_v == V_LAST);
    assign w_eof         = w_h_last && w_v_last;
    assign w_h_next      = w_h_last ? 16'd0 : r_h + 16'd1;
    assign w_v_next      = w_h_last ? (w_v_last ? 16'd0 : r_v + 16'd1) : r_v;
    // r_read_gate is only ever 1 in RUN, so underflows in DRAIN are ignored.
    assign w_underflow   = iRead_Req && iFifo_Empty && r_read_gate;
    assign w_primed      = (iFifo_Level >= PRIME_LVL);
    assign w_uf_cnt_next = (r_uf_cnt == 8'hFF) ? 8'hFF : r_uf_cnt + 8'd1;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state       <= ST_IDLE;
            r_h           <= 16'd0;
            r_v           <= 16'd0;
            r_read_gate   <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            r_running     <= 1'b0;
            r_uf_cnt      <= 8'd0;
            r_frame_cnt   <= 16'd0;
        end else begin
            r_frame_start <= 1'b0;
            r_line_start  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_h         <= 16'd0;
                    r_v         <= 16'd0;
                    r_read_gate <= 1'b0;
                    r_running   <= 1'b0;
                    if (iEnable) begin
                        r_state <= ST_PRIME;
                    end
                end

                ST_PRIME: begin
                    // Counters stay at 0 on the launch edge; the first RUN
                    // cycle is the (0,0) pixel of the new frame.
                    r_h <= 16'd0;
                    r_v <= 16'd0;
                    if (!iEnable) begin
                        r_state <= ST_IDLE;
                    end else if (w_primed) begin
                        r_state       <= ST_RUN;
                        r_read_gate   <= 1'b1;
                        r_running     <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_line_start  <= 1'b1;
                        r_frame_cnt   <= r_frame_cnt + 16'd1;
                    end
                end

                ST_RUN: begin
                    if (w_underflow) begin
                        r_uf_cnt <= w_uf_cnt_next;
                    end
                    if (w_eof) begin
                        r_h <= 16'd0;
                        r_v <= 16'd0;
                        if (!iEnable) begin
                            r_state     <= ST_IDLE;
                            r_read_gate <= 1'b0;
                            r_running   <= 1'b0;
                        end else if (w_underflow) begin
                            // Frame is already over: re-prime directly.
                            r_state     <= ST_PRIME;
                            r_read_gate <= 1'b0;
                            r_running   <= 1'b0;
                        end else begin
                            r_frame_start <= 1'b1;
                            r_line_start  <= 1'b1;
                            r_frame_cnt   <= r_frame_cnt + 16'd1;
                        end
                    end else begin
                        r_h          <= w_h_next;
                        r_v          <= w_v_next;
                        r_line_start <= w_h_last;
                        if (w_underflow) begin
                            r_state     <= ST_DRAIN;
                            r_read_gate <= 1'b0;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Keep sync timing continuous until the frame boundary.
                    if (w_eof) begin
                        r_h       <= 16'd0;
                        r_v       <= 16'd0;
                        r_running <= 1'b0;
                        r_state   <= iEnable ? ST_PRIME : ST_IDLE;
                    end else begin
                        r_h          <= w_h_next;
                        r_v          <= w_v_next;
                        r_line_start <= w_h_last;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oH_Cont        = r_h;
    assign oV_Cont        = r_v;
    assign oRead_Gate     = r_read_gate;
    assign oFrame_Start   = r_frame_start;
    assign oLine_Start    = r_line_start;
    assign oRunning       = r_running;
    assign oUnderflow_Cnt = r_uf_cnt;
    assign oFrame_Cnt     = r_frame_cnt;
    assign oDbg_State     = r_state;

endmodule
